// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Purpose  : Operation request and result return channels of the multi-byte
//            ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
   parameter int NBYTES = 2
);
   localparam int C_W = 8 * NBYTES;

   logic           op_valid;
   logic           op_ready;
   logic [C_W-1:0] op_a;
   logic [C_W-1:0] op_b;
   logic [3:0]     op_sel;
   logic           op_mode;
   logic           op_cin;

   logic           res_valid;
   logic           res_ready;
   logic [C_W-1:0] res_data;
   logic           res_carry;
   logic           res_zero;
   logic           res_neg;

   modport master (
      output op_valid, op_a, op_b, op_sel, op_mode, op_cin, res_ready,
      input  op_ready, res_valid, res_data, res_carry, res_zero, res_neg
   );

   modport slave (
      input  op_valid, op_a, op_b, op_sel, op_mode, op_cin, res_ready,
      output op_ready, res_valid, res_data, res_carry, res_zero, res_neg
   );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Runs a W-bit operation through the 8-bit ALU one byte per cycle,
//            LSB first, chaining the carry and assembling the result.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
   parameter int NBYTES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_seq_if.slave   bus,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic       alu_cf_in,
   output logic [3:0] alu_sel,
   output logic       alu_mode,
   input  logic [7:0] alu_out,
   input  logic       alu_cf_out
);
   localparam int         C_W    = 8 * NBYTES;
   localparam logic [2:0] C_LAST = 3'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [C_W-1:0] r_a_sh;
   logic [C_W-1:0] r_b_sh;
   logic [C_W-1:0] r_res;
   logic [C_W-1:0] w_a_nxt;
   logic [C_W-1:0] w_b_nxt;
   logic [C_W-1:0] w_res_nxt;
   logic [3:0]     r_sel;
   logic [2:0]     r_cnt;
   logic           r_mode;
   logic           r_cin;
   logic           r_carry;
   logic           r_res_carry;
   logic           w_op_ready;
   logic           w_res_valid;
   logic           w_accept;
   logic           w_last;
   logic           w_carry_true;
   logic           w_chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_op_ready  = 1'b0;
      w_res_valid = 1'b0;
      alu_a       = 8'h00;
      alu_b       = 8'h00;
      alu_cf_in   = 1'b0;
      alu_sel     = 4'h0;
      alu_mode    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_op_ready = 1'b1;
            if (bus.op_valid) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            alu_a     = r_a_sh[7:0];
            alu_b     = r_b_sh[7:0];
            alu_cf_in = r_carry;
            alu_sel   = r_sel;
            alu_mode  = r_mode;
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_res_valid = 1'b1;
            if (bus.res_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_accept = w_op_ready & bus.op_valid;
   assign w_last   = (r_cnt == C_LAST);

   // These functions take cf as a true carry; all others expect its inverse.
   always_comb begin
      case (r_sel)
         4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1110: w_carry_true = 1'b1;
         default:                                    w_carry_true = 1'b0;
      endcase
   end

   assign w_chain = r_mode ? r_cin : (w_carry_true ? alu_cf_out : ~alu_cf_out);

   // A single-byte build has nothing to shift beyond the ALU byte.
   generate
      if (NBYTES == 1) begin : g_single
         assign w_res_nxt = alu_out;
         assign w_a_nxt   = '0;
         assign w_b_nxt   = '0;
      end else begin : g_multi
         assign w_res_nxt = {alu_out, r_res[C_W-1:8]};
         assign w_a_nxt   = {8'h00, r_a_sh[C_W-1:8]};
         assign w_b_nxt   = {8'h00, r_b_sh[C_W-1:8]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh      <= '0;
         r_b_sh      <= '0;
         r_res       <= '0;
         r_sel       <= 4'h0;
         r_cnt       <= 3'd0;
         r_mode      <= 1'b0;
         r_cin       <= 1'b0;
         r_carry     <= 1'b0;
         r_res_carry <= 1'b0;
      end else if (w_accept) begin
         r_a_sh  <= bus.op_a;
         r_b_sh  <= bus.op_b;
         r_sel   <= bus.op_sel;
         r_mode  <= bus.op_mode;
         r_cin   <= bus.op_cin;
         r_carry <= bus.op_cin;
         r_cnt   <= 3'd0;
      end else if (r_state == S_RUN) begin
         r_res   <= w_res_nxt;
         r_a_sh  <= w_a_nxt;
         r_b_sh  <= w_b_nxt;
         r_carry <= w_chain;
         r_cnt   <= r_cnt + 3'd1;
         if (w_last) begin
            r_res_carry <= r_mode ? 1'b0 : alu_cf_out;
         end
      end
   end

   assign bus.op_ready  = w_op_ready;
   assign bus.res_valid = w_res_valid;
   assign bus.res_data  = r_res;
   assign bus.res_carry = r_res_carry;
   assign bus.res_zero  = (r_res == '0);
   assign bus.res_neg   = r_res[C_W-1];
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq at NBYTES = 1, 2 and 4 against a
//            full-width arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] tb_a = '0;
   logic [63:0] tb_b = '0;
   logic [3:0]  tb_sel = '0;
   logic        tb_mode = 1'b0;
   logic        tb_cin = 1'b0;
   logic [2:0]  tb_valid = '0;
   logic [2:0]  tb_rready = '0;
   int          errors = 0;
   int          checks = 0;

   logic [7:0]  alu_a_w [3];
   logic [7:0]  alu_b_w [3];
   logic        alu_cfi_w [3];
   logic [3:0]  alu_sel_w [3];
   logic        alu_mode_w [3];
   logic [7:0]  alu_out_w [3];
   logic        alu_cfo_w [3];

   always #5 clk = ~clk;

   // Behavioural 8-bit ALU: cf_in is a true carry for the carry-true group,
   // an inverted borrow for the rest; cf_out in logic mode is junk.
   function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic cf, input logic [3:0] sel,
                                            input logic md);
      logic [7:0] bx;
      logic [8:0] s;
      bx = (sel[3] & sel[1]) ? ~b : b;
      if (md) begin
         case (sel[1:0])
            2'd0:    s = {a[0] ^ b[7], a & b};
            2'd1:    s = {a[0] ^ b[7], a | b};
            2'd2:    s = {a[0] ^ b[7], a ^ b};
            default: s = {a[0] ^ b[7], ~a};
         endcase
      end else if (sel inside {4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1110}) begin
         s = {1'b0, a} + {1'b0, bx} + 9'(cf);
      end else begin
         s = {1'b0, a} - {1'b0, bx} - 9'(!cf);
      end
      return s;
   endfunction

   // Whole-word reference: returns {carry, data}.
   function automatic logic [64:0] ref_op(input int n, input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] sel, input logic md, input logic ci);
      logic [72:0] mask, aa, bb, s, sub;
      logic        cy;
      int          w;
      w    = 8 * n;
      mask = (73'd1 << w) - 73'd1;
      aa   = {9'd0, a} & mask;
      bb   = {9'd0, b} & mask;
      cy   = 1'b0;
      if (md) begin
         case (sel[1:0])
            2'd0:    s = aa & bb;
            2'd1:    s = aa | bb;
            2'd2:    s = aa ^ bb;
            default: s = ~aa & mask;
         endcase
      end else begin
         if (sel[3] & sel[1]) bb = ~bb & mask;
         if (sel inside {4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1110}) begin
            s  = aa + bb + 73'(ci);
            cy = s[w];
            s  = s & mask;
         end else begin
            sub = bb + 73'(!ci);
            cy  = (aa < sub);
            s   = (aa - sub) & mask;
         end
      end
      return {cy, s[63:0]};
   endfunction

   alu_seq_if #(.NBYTES(1)) u_if0 ();
   alu_seq_if #(.NBYTES(2)) u_if1 ();
   alu_seq_if #(.NBYTES(4)) u_if2 ();

   assign u_if0.op_valid = tb_valid[0];
   assign u_if0.op_a = tb_a[7:0];
   assign u_if0.op_b = tb_b[7:0];
   assign u_if0.op_sel = tb_sel;
   assign u_if0.op_mode = tb_mode;
   assign u_if0.op_cin = tb_cin;
   assign u_if0.res_ready = tb_rready[0];

   assign u_if1.op_valid = tb_valid[1];
   assign u_if1.op_a = tb_a[15:0];
   assign u_if1.op_b = tb_b[15:0];
   assign u_if1.op_sel = tb_sel;
   assign u_if1.op_mode = tb_mode;
   assign u_if1.op_cin = tb_cin;
   assign u_if1.res_ready = tb_rready[1];

   assign u_if2.op_valid = tb_valid[2];
   assign u_if2.op_a = tb_a[31:0];
   assign u_if2.op_b = tb_b[31:0];
   assign u_if2.op_sel = tb_sel;
   assign u_if2.op_mode = tb_mode;
   assign u_if2.op_cin = tb_cin;
   assign u_if2.res_ready = tb_rready[2];

   alu_seq #(.NBYTES(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(u_if0.slave),
      .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]), .alu_cf_in(alu_cfi_w[0]),
      .alu_sel(alu_sel_w[0]), .alu_mode(alu_mode_w[0]),
      .alu_out(alu_out_w[0]), .alu_cf_out(alu_cfo_w[0])
   );
   alu_seq #(.NBYTES(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(u_if1.slave),
      .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]), .alu_cf_in(alu_cfi_w[1]),
      .alu_sel(alu_sel_w[1]), .alu_mode(alu_mode_w[1]),
      .alu_out(alu_out_w[1]), .alu_cf_out(alu_cfo_w[1])
   );
   alu_seq #(.NBYTES(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .bus(u_if2.slave),
      .alu_a(alu_a_w[2]), .alu_b(alu_b_w[2]), .alu_cf_in(alu_cfi_w[2]),
      .alu_sel(alu_sel_w[2]), .alu_mode(alu_mode_w[2]),
      .alu_out(alu_out_w[2]), .alu_cf_out(alu_cfo_w[2])
   );

   assign {alu_cfo_w[0], alu_out_w[0]} = alu_model(alu_a_w[0], alu_b_w[0], alu_cfi_w[0], alu_sel_w[0], alu_mode_w[0]);
   assign {alu_cfo_w[1], alu_out_w[1]} = alu_model(alu_a_w[1], alu_b_w[1], alu_cfi_w[1], alu_sel_w[1], alu_mode_w[1]);
   assign {alu_cfo_w[2], alu_out_w[2]} = alu_model(alu_a_w[2], alu_b_w[2], alu_cfi_w[2], alu_sel_w[2], alu_mode_w[2]);

   function automatic int nb(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
   endfunction

   task automatic sample(input int d, output logic rdy, output logic vld, output logic [63:0] data,
                         output logic cy, output logic zf, output logic nf, output logic [21:0] abus);
      abus = {alu_a_w[d], alu_b_w[d], alu_cfi_w[d], alu_sel_w[d], alu_mode_w[d]};
      case (d)
         0: begin
            rdy = u_if0.op_ready; vld = u_if0.res_valid; data = 64'(u_if0.res_data);
            cy = u_if0.res_carry; zf = u_if0.res_zero; nf = u_if0.res_neg;
         end
         1: begin
            rdy = u_if1.op_ready; vld = u_if1.res_valid; data = 64'(u_if1.res_data);
            cy = u_if1.res_carry; zf = u_if1.res_zero; nf = u_if1.res_neg;
         end
         default: begin
            rdy = u_if2.op_ready; vld = u_if2.res_valid; data = 64'(u_if2.res_data);
            cy = u_if2.res_carry; zf = u_if2.res_zero; nf = u_if2.res_neg;
         end
      endcase
   endtask

   // Issues one operation, waits for the result, then completes the handshake.
   task automatic do_op(input int d, input logic [63:0] a, input logic [63:0] b, input logic [3:0] sel,
                        input logic md, input logic ci, output logic [63:0] data, output logic cy,
                        output logic zf, output logic nf, output int lat, output logic cfi_ok,
                        output logic idle_ok);
      logic rdy, vld;
      logic [21:0] abus;
      int guard;
      @(negedge clk);
      tb_a = a; tb_b = b; tb_sel = sel; tb_mode = md; tb_cin = ci;
      tb_valid[d] = 1'b1;
      sample(d, rdy, vld, data, cy, zf, nf, abus);
      guard = 0;
      while (!rdy && guard < 50) begin
         @(negedge clk);
         guard++;
         sample(d, rdy, vld, data, cy, zf, nf, abus);
      end
      if (!rdy) begin
         checks++; errors++;
         $display("FAIL accept_timeout dut%0d op_ready=%b required=1", d, rdy);
      end
      @(posedge clk);
      #1 tb_valid[d] = 1'b0;
      lat = 0;
      cfi_ok = 1'b1;
      sample(d, rdy, vld, data, cy, zf, nf, abus);
      while (!vld && lat < 40) begin
         if (md && abus[5] !== ci) cfi_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
         sample(d, rdy, vld, data, cy, zf, nf, abus);
      end
      if (!vld) begin
         checks++; errors++;
         $display("FAIL result_timeout dut%0d res_valid=%b required=1", d, vld);
      end
      idle_ok = (abus === 22'd0);
      @(negedge clk);
      tb_rready[d] = 1'b1;
      @(posedge clk);
      #1 tb_rready[d] = 1'b0;
   endtask

   task automatic test_reset;
      logic rdy, vld, cy, zf, nf;
      logic [63:0] data;
      logic [21:0] abus;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         sample(d, rdy, vld, data, cy, zf, nf, abus);
         checks++;
         if (rdy !== 1'b1 || vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake dut%0d got rdy=%b vld=%b required rdy=1 vld=0", d, rdy, vld);
         end
         checks++;
         if (data !== 64'd0 || cy !== 1'b0 || zf !== 1'b1 || nf !== 1'b0) begin
            errors++;
            $display("FAIL reset_result dut%0d got data=%h c=%b z=%b n=%b required 0/0/1/0", d, data, cy, zf, nf);
         end
         checks++;
         if (abus !== 22'd0) begin
            errors++;
            $display("FAIL reset_alu_outs dut%0d got=%h required=0", d, abus);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed;
      logic [15:0] va [5];
      logic [15:0] vb [5];
      logic [3:0]  vs [5];
      logic        vm [5];
      logic        vc [5];
      logic [15:0] ed [5];
      logic        ec [5];
      logic        ez [5];
      logic        en [5];
      logic [63:0] data;
      logic cy, zf, nf, cfi_ok, idle_ok, rdy, vld;
      logic [21:0] abus;
      int lat;
      va = '{16'h12FF, 16'hFFFF, 16'h1000, 16'h0000, 16'hA5A5};
      vb = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0FF0};
      vs = '{4'b1001, 4'b1001, 4'b0110, 4'b0110, 4'b0110};
      vm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      ed = '{16'h1300, 16'h0000, 16'h0FFF, 16'hFFFF, 16'hAA55};
      ec = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      ez = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      en = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         do_op(1, 64'(va[i]), 64'(vb[i]), vs[i], vm[i], vc[i], data, cy, zf, nf, lat, cfi_ok, idle_ok);
         checks++;
         if (data !== 64'(ed[i]) || cy !== ec[i]) begin
            errors++;
            $display("FAIL directed_data v%0d got=%h c=%b required=%h c=%b", i, data, cy, ed[i], ec[i]);
         end
         checks++;
         if (zf !== ez[i] || nf !== en[i]) begin
            errors++;
            $display("FAIL directed_flags v%0d got z=%b n=%b required z=%b n=%b", i, zf, nf, ez[i], en[i]);
         end
         checks++;
         if (lat != 2 || !cfi_ok || !idle_ok) begin
            errors++;
            $display("FAIL directed_timing v%0d got lat=%0d cfi_ok=%b idle_ok=%b required 2/1/1", i, lat, cfi_ok, idle_ok);
         end
         sample(1, rdy, vld, data, cy, zf, nf, abus);
         checks++;
         if (rdy !== 1'b1 || vld !== 1'b0) begin
            errors++;
            $display("FAIL directed_release v%0d got rdy=%b vld=%b required rdy=1 vld=0", i, rdy, vld);
         end
      end
   endtask

   task automatic test_random;
      logic [63:0] a, b, data, ed;
      logic [64:0] r;
      logic [3:0] sel;
      logic md, ci, cy, zf, nf, cfi_ok, idle_ok;
      int lat, n;
      for (int d = 0; d < 3; d++) begin
         n = nb(d);
         for (int k = 0; k < 30; k++) begin
            a   = {$urandom(), $urandom()};
            b   = {$urandom(), $urandom()};
            if (k % 7 == 0) b = 64'd0;
            if (k % 5 == 0) a = '1;
            sel = 4'($urandom_range(0, 15));
            md  = 1'($urandom_range(0, 3) == 0);
            ci  = 1'($urandom_range(0, 1));
            r   = ref_op(n, a, b, sel, md, ci);
            ed  = r[63:0];
            do_op(d, a, b, sel, md, ci, data, cy, zf, nf, lat, cfi_ok, idle_ok);
            checks++;
            if (data !== ed || cy !== r[64]) begin
               errors++;
               $display("FAIL rand_data dut%0d sel=%h m=%b ci=%b got=%h c=%b required=%h c=%b",
                        d, sel, md, ci, data, cy, ed, r[64]);
            end
            checks++;
            if (zf !== (ed == 64'd0) || nf !== ed[8*n-1]) begin
               errors++;
               $display("FAIL rand_flags dut%0d got z=%b n=%b required z=%b n=%b", d, zf, nf, (ed == 64'd0), ed[8*n-1]);
            end
            checks++;
            if (lat != n || !cfi_ok || !idle_ok) begin
               errors++;
               $display("FAIL rand_timing dut%0d got lat=%0d cfi_ok=%b idle_ok=%b required %0d/1/1", d, lat, cfi_ok, idle_ok, n);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      logic rdy, vld, cy, zf, nf, c0, cfi_ok, idle_ok;
      logic [63:0] data, d0;
      logic [64:0] r;
      logic [21:0] abus;
      int guard, lat;
      @(negedge clk);
      tb_a = 64'h1234; tb_b = 64'h0101; tb_sel = 4'b1001; tb_mode = 1'b0; tb_cin = 1'b0;
      tb_valid[1] = 1'b1;
      @(posedge clk);
      #1 tb_valid[1] = 1'b0;
      guard = 0;
      sample(1, rdy, vld, data, cy, zf, nf, abus);
      while (!vld && guard < 20) begin
         @(posedge clk);
         #1 guard++;
         sample(1, rdy, vld, data, cy, zf, nf, abus);
      end
      checks++;
      if (vld !== 1'b1 || data !== 64'h1335 || cy !== 1'b0) begin
         errors++;
         $display("FAIL bp_first got vld=%b data=%h c=%b required vld=1 data=1335 c=0", vld, data, cy);
      end
      d0 = data; c0 = cy;
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            tb_a = 64'h7777; tb_b = 64'h1111; tb_valid[1] = 1'b1;
         end else begin
            tb_valid[1] = 1'b0;
         end
         @(posedge clk);
         #1 sample(1, rdy, vld, data, cy, zf, nf, abus);
         checks++;
         if (vld !== 1'b1 || rdy !== 1'b0 || data !== d0 || cy !== c0 || abus !== 22'd0) begin
            errors++;
            $display("FAIL bp_hold cyc%0d got vld=%b rdy=%b data=%h c=%b alu=%h required 1/0/%h/%b/0",
                     cyc, vld, rdy, data, cy, abus, d0, c0);
         end
      end
      @(negedge clk);
      tb_rready[1] = 1'b1;
      @(posedge clk);
      #1 tb_rready[1] = 1'b0;
      sample(1, rdy, vld, data, cy, zf, nf, abus);
      checks++;
      if (rdy !== 1'b1 || vld !== 1'b0) begin
         errors++;
         $display("FAIL bp_release got rdy=%b vld=%b required rdy=1 vld=0", rdy, vld);
      end
      r = ref_op(2, 64'h8001, 64'h8000, 4'b1001, 1'b0, 1'b1);
      do_op(1, 64'h8001, 64'h8000, 4'b1001, 1'b0, 1'b1, data, cy, zf, nf, lat, cfi_ok, idle_ok);
      checks++;
      if (data !== r[63:0] || cy !== r[64] || lat != 2) begin
         errors++;
         $display("FAIL bp_next got data=%h c=%b lat=%0d required data=%h c=%b lat=2", data, cy, lat, r[63:0], r[64]);
      end
   endtask

   task automatic test_reset_mid_run;
      logic rdy, vld, cy, zf, nf, cfi_ok, idle_ok, seen;
      logic [63:0] data;
      logic [64:0] r;
      logic [21:0] abus;
      int lat;
      @(negedge clk);
      tb_a = 64'h11223344; tb_b = 64'h01010101; tb_sel = 4'b1001; tb_mode = 1'b0; tb_cin = 1'b0;
      tb_valid[2] = 1'b1;
      @(posedge clk);
      #1 tb_valid[2] = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 sample(2, rdy, vld, data, cy, zf, nf, abus);
      checks++;
      if (rdy !== 1'b1 || vld !== 1'b0 || data !== 64'd0 || cy !== 1'b0 || zf !== 1'b1 || nf !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset got rdy=%b vld=%b data=%h c=%b z=%b n=%b required 1/0/0/0/1/0",
                  rdy, vld, data, cy, zf, nf);
      end
      checks++;
      if (abus !== 22'd0) begin
         errors++;
         $display("FAIL midrun_alu_outs got=%h required=0", abus);
      end
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1 sample(2, rdy, vld, data, cy, zf, nf, abus);
         if (vld !== 1'b0) seen = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1 sample(2, rdy, vld, data, cy, zf, nf, abus);
         if (vld !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL midrun_no_result got res_valid=1 required=0");
      end
      r = ref_op(4, 64'hDEADBEEF, 64'h21524111, 4'b1001, 1'b0, 1'b1);
      do_op(2, 64'hDEADBEEF, 64'h21524111, 4'b1001, 1'b0, 1'b1, data, cy, zf, nf, lat, cfi_ok, idle_ok);
      checks++;
      if (data !== r[63:0] || cy !== r[64] || zf !== (r[63:0] == 64'd0) || lat != 4) begin
         errors++;
         $display("FAIL midrun_next got data=%h c=%b z=%b lat=%0d required data=%h c=%b lat=4",
                  data, cy, zf, lat, r[63:0], r[64]);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_random;
      test_backpressure;
      test_reset_mid_run;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end
endmodule
`default_nettype wire
